// File: rtl/paint_scheduler_if.sv
// paint_scheduler_if: host-side descriptor/config bus plus paint_element engine handshake
interface paint_scheduler_if #(
  parameter int COOR_WIDTH = 12,
  parameter int IDX_WIDTH  = 4
);
  logic                  frame_start;
  logic                  cfg_we;
  logic [IDX_WIDTH-1:0]  cfg_idx;
  logic                  cfg_enable;
  logic [COOR_WIDTH-1:0] cfg_sprite_x;
  logic [COOR_WIDTH-1:0] cfg_sprite_y;
  logic [COOR_WIDTH-1:0] cfg_frame_x;
  logic [COOR_WIDTH-1:0] cfg_frame_y;
  logic [COOR_WIDTH-1:0] cfg_width;
  logic [COOR_WIDTH-1:0] cfg_height;
  logic                  cfg_count_we;
  logic [IDX_WIDTH:0]    cfg_count;
  logic                  pe_rst;
  logic [COOR_WIDTH-1:0] pe_sprite_x;
  logic [COOR_WIDTH-1:0] pe_sprite_y;
  logic [COOR_WIDTH-1:0] pe_frame_x;
  logic [COOR_WIDTH-1:0] pe_frame_y;
  logic [COOR_WIDTH-1:0] pe_width;
  logic [COOR_WIDTH-1:0] pe_height;
  logic                  pe_finished;
  logic                  busy;
  logic [IDX_WIDTH-1:0]  cur_idx;
  logic                  frame_done;
  logic                  cfg_err;
  logic                  overrun;
  modport master (
    output frame_start, cfg_we, cfg_idx, cfg_enable, cfg_sprite_x, cfg_sprite_y,
           cfg_frame_x, cfg_frame_y, cfg_width, cfg_height, cfg_count_we, cfg_count,
           pe_finished,
    input  pe_rst, pe_sprite_x, pe_sprite_y, pe_frame_x, pe_frame_y, pe_width, pe_height,
           busy, cur_idx, frame_done, cfg_err, overrun
  );
  modport slave (
    input  frame_start, cfg_we, cfg_idx, cfg_enable, cfg_sprite_x, cfg_sprite_y,
           cfg_frame_x, cfg_frame_y, cfg_width, cfg_height, cfg_count_we, cfg_count,
           pe_finished,
    output pe_rst, pe_sprite_x, pe_sprite_y, pe_frame_x, pe_frame_y, pe_width, pe_height,
           busy, cur_idx, frame_done, cfg_err, overrun
  );
endinterface

// File: rtl/paint_scheduler.sv
// paint_scheduler: walks a sprite descriptor table each frame, driving one paint_element per entry
module paint_scheduler #(
  parameter int COOR_WIDTH   = 12,
  parameter int MAX_ELEMENTS = 16,
  parameter int IDX_WIDTH    = 4
) (
  input logic              clk_33m,
  input logic              rst,
  paint_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FETCH, START, WAIT, DONE} state_t;
  localparam logic [IDX_WIDTH:0] MAX_CNT = (IDX_WIDTH+1)'(MAX_ELEMENTS);
  localparam logic [IDX_WIDTH:0] ONE = (IDX_WIDTH+1)'(1);
  state_t                state_q, state_d;
  logic [IDX_WIDTH:0]    idx_q, idx_d, count_q, count_d;
  logic [MAX_ELEMENTS-1:0] en_q;
  logic [COOR_WIDTH-1:0] sx_q [MAX_ELEMENTS];
  logic [COOR_WIDTH-1:0] sy_q [MAX_ELEMENTS];
  logic [COOR_WIDTH-1:0] fx_q [MAX_ELEMENTS];
  logic [COOR_WIDTH-1:0] fy_q [MAX_ELEMENTS];
  logic [COOR_WIDTH-1:0] w_q  [MAX_ELEMENTS];
  logic [COOR_WIDTH-1:0] h_q  [MAX_ELEMENTS];
  logic [COOR_WIDTH-1:0] pe_sx_q, pe_sy_q, pe_fx_q, pe_fy_q, pe_w_q, pe_h_q;
  logic                  frame_done_q, cfg_err_q, overrun_q;
  logic                  idle, tbl_wr, skip, latch;
  logic [IDX_WIDTH-1:0]  sel;
  assign idle    = state_q == IDLE;
  assign tbl_wr  = idle && bus.cfg_we && ({1'b0, bus.cfg_idx} < MAX_CNT);
  assign count_d = !(idle && bus.cfg_count_we) ? count_q :
                   (bus.cfg_count > MAX_CNT) ? MAX_CNT : bus.cfg_count;
  assign sel     = idx_q[IDX_WIDTH-1:0];
  assign skip    = !en_q[sel] || w_q[sel] == '0 || h_q[sel] == '0;
  // count_d lets a frame_start that coincides with a count write use the new count
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          idx_d   = '0;
          state_d = count_d == '0 ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (idx_q == count_q) state_d = DONE;
        else if (skip) idx_d = idx_q + ONE;
        else begin
          latch   = 1'b1;
          state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (bus.pe_finished) begin
          idx_d   = idx_q + ONE;
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_33m or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      en_q         <= '0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
      pe_sx_q      <= '0;
      pe_sy_q      <= '0;
      pe_fx_q      <= '0;
      pe_fy_q      <= '0;
      pe_w_q       <= '0;
      pe_h_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      frame_done_q <= state_q == DONE;
      cfg_err_q    <= cfg_err_q | (!idle && (bus.cfg_we || bus.cfg_count_we));
      overrun_q    <= overrun_q | (!idle && bus.frame_start);
      if (tbl_wr) en_q[bus.cfg_idx] <= bus.cfg_enable;
      if (latch) begin
        pe_sx_q <= sx_q[sel];
        pe_sy_q <= sy_q[sel];
        pe_fx_q <= fx_q[sel];
        pe_fy_q <= fy_q[sel];
        pe_w_q  <= w_q[sel];
        pe_h_q  <= h_q[sel];
      end
    end
  end
  // descriptor payload needs no reset: an entry is only read once its enable has been written
  always_ff @(posedge clk_33m) begin
    if (tbl_wr) begin
      sx_q[bus.cfg_idx] <= bus.cfg_sprite_x;
      sy_q[bus.cfg_idx] <= bus.cfg_sprite_y;
      fx_q[bus.cfg_idx] <= bus.cfg_frame_x;
      fy_q[bus.cfg_idx] <= bus.cfg_frame_y;
      w_q[bus.cfg_idx]  <= bus.cfg_width;
      h_q[bus.cfg_idx]  <= bus.cfg_height;
    end
  end
  assign bus.pe_rst      = state_q == START;
  assign bus.busy        = !idle;
  assign bus.cur_idx     = idle ? '0 : sel;
  assign bus.frame_done  = frame_done_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.overrun     = overrun_q;
  assign bus.pe_sprite_x = pe_sx_q;
  assign bus.pe_sprite_y = pe_sy_q;
  assign bus.pe_frame_x  = pe_fx_q;
  assign bus.pe_frame_y  = pe_fy_q;
  assign bus.pe_width    = pe_w_q;
  assign bus.pe_height   = pe_h_q;
endmodule
